// File: rtl/cpu_mem_responder.sv
// Memory-side responder: arbitrates fetch and load/store requests onto one
// single-ported word array. Optional round-robin arbitration: MEM_ROUND_ROBIN_EN.
//
// state | meaning
// IDLE  | no transaction; sample requests, latch winner, load countdown
// SRV_I | serving a fetch; respond when countdown reaches zero
// SRV_D | serving a load/store; respond (and commit store) at zero
module cpu_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_mem_address,
  input  logic        i_mem_read,
  output logic [31:0] i_mem_rdata,
  output logic        i_mem_resp,
  input  logic [31:0] d_mem_address,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [3:0]  d_mem_byte_enable,
  input  logic [31:0] d_mem_wdata,
  output logic [31:0] d_mem_rdata,
  output logic        d_mem_resp
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, SRV_I, SRV_D} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  d_grant;
  logic                  mem_we;
  logic                  d_req;
  logic [31:0]           mem_q [DEPTH];

`ifdef MEM_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;  // 0: D next on contention, 1: I next
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_mem_address[31:DEPTH_LOG2+2], i_mem_address[1:0],
                              d_mem_address[31:DEPTH_LOG2+2], d_mem_address[1:0]};

  assign d_req = d_mem_read | d_mem_write;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    d_grant     = 1'b0;
    mem_we      = 1'b0;
    i_mem_resp  = 1'b0;
    d_mem_resp  = 1'b0;
    i_mem_rdata = '0;
    d_mem_rdata = '0;
`ifdef MEM_ROUND_ROBIN_EN
    ptr_d = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req || i_mem_read) begin
`ifdef MEM_ROUND_ROBIN_EN
          d_grant = d_req && (!i_mem_read || !ptr_q);
          if (d_req && i_mem_read) ptr_d = ~ptr_q;
`else
          d_grant = d_req;
`endif
          cnt_d = CNT_INIT;
          if (d_grant) begin
            state_d = SRV_D;
            idx_d   = d_mem_address[DEPTH_LOG2+1:2];
            wr_d    = d_mem_write;
            be_d    = d_mem_byte_enable;
            wdata_d = d_mem_wdata;
          end else begin
            state_d = SRV_I;
            idx_d   = i_mem_address[DEPTH_LOG2+1:2];
            wr_d    = 1'b0;
          end
        end
      end
      SRV_I, SRV_D: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          // Read returns the pre-store word; the store lands on the closing edge.
          if (state_q == SRV_I) begin
            i_mem_resp  = 1'b1;
            i_mem_rdata = mem_q[idx_q];
          end else begin
            d_mem_resp  = 1'b1;
            d_mem_rdata = mem_q[idx_q];
            mem_we      = wr_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
`ifdef MEM_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
`ifdef MEM_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Reset in the response cycle aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: main instance at LATENCY=2 and a
// second instance at LATENCY=1 for the held-request throughput case.
module tb_cpu_mem_responder;

  localparam int LAT  = 2;
  localparam int MASK = 1023;
`ifdef MEM_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] i_mem_address, i_mem_rdata, d_mem_address, d_mem_wdata, d_mem_rdata;
  logic        i_mem_read, i_mem_resp, d_mem_read, d_mem_write, d_mem_resp;
  logic [3:0]  d_mem_byte_enable;

  logic [31:0] f_i_mem_address, f_i_mem_rdata, f_d_mem_address, f_d_mem_wdata, f_d_mem_rdata;
  logic        f_i_mem_read, f_i_mem_resp, f_d_mem_read, f_d_mem_write, f_d_mem_resp;
  logic [3:0]  f_d_mem_byte_enable;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  exp_t        sb1_q[$];
  logic [31:0] model [int];

  cpu_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_mem_address(i_mem_address), .i_mem_read(i_mem_read),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_address(d_mem_address), .d_mem_read(d_mem_read),
    .d_mem_write(d_mem_write), .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp)
  );

  cpu_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .i_mem_address(f_i_mem_address), .i_mem_read(f_i_mem_read),
    .i_mem_rdata(f_i_mem_rdata), .i_mem_resp(f_i_mem_resp),
    .d_mem_address(f_d_mem_address), .d_mem_read(f_d_mem_read),
    .d_mem_write(f_d_mem_write), .d_mem_byte_enable(f_d_mem_byte_enable),
    .d_mem_wdata(f_d_mem_wdata), .d_mem_rdata(f_d_mem_rdata), .d_mem_resp(f_d_mem_resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2) & MASK;
    return model.exists(idx) ? model[idx] : 32'h0;
  endfunction

  // Pops one expectation per response and checks port, data, and idle rdata.
  task automatic mon_port(input bit sel, input logic ir, input logic dr,
                          input logic [31:0] ird, input logic [31:0] drd);
    exp_t e;
    if (ir || dr) begin
      check("one_resp", 32'(ir && dr), 32'h0);
      if ((sel ? sb1_q.size() : sb_q.size()) == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        e = sel ? sb1_q.pop_front() : sb_q.pop_front();
        check("resp_port_is_d", 32'(dr), 32'(e.is_d));
        if (e.chk_data) check("resp_rdata", dr ? drd : ird, e.data);
      end
    end
    if (!ir) check("i_rdata_idle", ird, 32'h0);
    if (!dr) check("d_rdata_idle", drd, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_port(1'b0, i_mem_resp, d_mem_resp, i_mem_rdata, d_mem_rdata);
      mon_port(1'b1, f_i_mem_resp, f_d_mem_resp, f_i_mem_rdata, f_d_mem_rdata);
    end
  end

  // Waits for a response on one port of the main instance, scrambling the
  // held inputs after acceptance; they must have been latched.
  task automatic wait_resp(input bit is_d, input int exp_n, input string tag);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      got = is_d ? d_mem_resp : i_mem_resp;
      if (!got && n == 1) begin
        @(posedge clk);
        #1;
        if (is_d) begin
          d_mem_address = ~d_mem_address;
          d_mem_wdata   = ~d_mem_wdata;
          d_mem_byte_enable = ~d_mem_byte_enable;
        end else begin
          i_mem_address = ~i_mem_address;
        end
      end
    end
    if (!got) check({tag, "_timeout"}, 32'h0, 32'h1);
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
    @(posedge clk);
    #1;
  endtask

  task automatic d_op(input bit rd, input bit wr, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] w);
    exp_t        e;
    logic [31:0] old;
    old        = model_rd(a);
    e.is_d     = 1'b1;
    e.chk_data = rd;
    e.data     = old;
    sb_q.push_back(e);
    if (wr) model[int'(a >> 2) & MASK] = merge(old, w, be);
    d_mem_read = rd; d_mem_write = wr; d_mem_byte_enable = be;
    d_mem_address = a; d_mem_wdata = w;
    wait_resp(1'b1, LAT + 1, "d");
    d_mem_read = 1'b0; d_mem_write = 1'b0;
  endtask

  task automatic i_op(input logic [31:0] a);
    exp_t e;
    e.is_d = 1'b0; e.chk_data = 1'b1; e.data = model_rd(a);
    sb_q.push_back(e);
    i_mem_read = 1'b1; i_mem_address = a;
    wait_resp(1'b0, LAT + 1, "i");
    i_mem_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    bit   d_first, got;

    rst = 1'b1;
    i_mem_address = '0; i_mem_read = 1'b0;
    d_mem_address = '0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    d_mem_byte_enable = '0; d_mem_wdata = '0;
    f_i_mem_address = '0; f_i_mem_read = 1'b0;
    f_d_mem_address = '0; f_d_mem_read = 1'b0; f_d_mem_write = 1'b0;
    f_d_mem_byte_enable = '0; f_d_mem_wdata = '0;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_i_resp", 32'(i_mem_resp), 32'h0);
      check("rst_d_resp", 32'(d_mem_resp), 32'h0);
      check("rst_i_rdata", i_mem_rdata, 32'h0);
      check("rst_d_rdata", d_mem_rdata, 32'h0);
    end
    rst = 1'b0;

    d_op(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
    d_op(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
    check("model_deadbeef", model_rd(32'h40), 32'hDEAD_BEEF);

    d_op(1'b0, 1'b1, 4'b0001, 32'h0000_0040, 32'h0000_00AA);
    d_op(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
    check("model_deadbeaa", model_rd(32'h40), 32'hDEAD_BEAA);
    i_op(32'h0000_1040);

    d_op(1'b0, 1'b1, 4'hF, 32'h0000_0044, 32'h0102_0304);
    d_op(1'b1, 1'b1, 4'b1100, 32'h0000_0046, 32'hAABB_CCDD);
    d_op(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0);
    d_op(1'b0, 1'b1, 4'b0000, 32'h0000_0044, 32'hFFFF_FFFF);
    d_op(1'b1, 1'b0, 4'h0, 32'hFFFF_F044, 32'h0);
    check("model_aabb0304", model_rd(32'h44), 32'hAABB_0304);

    for (int rep = 0; rep < 4; rep++) begin
      d_first = RR ? (rep % 2 == 0) : 1'b1;
      e.chk_data = 1'b1; e.data = model_rd(32'h40);
      e.is_d = d_first;  sb_q.push_back(e);
      e.is_d = !d_first; sb_q.push_back(e);
      d_mem_read = 1'b1; d_mem_address = 32'h40;
      i_mem_read = 1'b1; i_mem_address = 32'h1040;
      n = 0; got = 1'b0;
      while (n < 20 && !got) begin
        @(negedge clk); n++;
        got = i_mem_resp || d_mem_resp;
      end
      if (!got) check("arb_first_timeout", 32'h0, 32'h1);
      check("arb_first_latency", 32'(n), 32'(LAT + 1));
      check("arb_first_is_d", 32'(d_mem_resp), 32'(d_first));
      @(posedge clk); #1;
      if (d_first) d_mem_read = 1'b0; else i_mem_read = 1'b0;
      got = 1'b0;
      while (n < 30 && !got) begin
        @(negedge clk); n++;
        got = d_first ? i_mem_resp : d_mem_resp;
      end
      if (!got) check("arb_second_timeout", 32'h0, 32'h1);
      check("arb_second_latency", 32'(n), 32'(2 * LAT + 2));
      @(posedge clk); #1;
      d_mem_read = 1'b0; i_mem_read = 1'b0;
    end

    d_op(1'b0, 1'b1, 4'hF, 32'h0000_0080, 32'h1111_1111);
    d_mem_write = 1'b1; d_mem_byte_enable = 4'hF;
    d_mem_address = 32'h80; d_mem_wdata = 32'h2222_2222;
    @(negedge clk);
    check("abort_no_early_resp", 32'(d_mem_resp), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; d_mem_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'(d_mem_resp), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    d_op(1'b1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);

    e.is_d = 1'b1; e.chk_data = 1'b0; e.data = 32'h0;
    sb1_q.push_back(e);
    f_d_mem_write = 1'b1; f_d_mem_byte_enable = 4'hF;
    f_d_mem_address = 32'h10; f_d_mem_wdata = 32'hCAFE_F00D;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk); n++;
      got = f_d_mem_resp;
    end
    if (!got) check("lat1_store_timeout", 32'h0, 32'h1);
    check("lat1_store_latency", 32'(n), 32'h2);
    @(posedge clk); #1;
    f_d_mem_write = 1'b0;
    for (int k = 0; k < 6; k++) begin
      e.is_d = 1'b1; e.chk_data = 1'b1; e.data = 32'hCAFE_F00D;
      sb1_q.push_back(e);
    end
    f_d_mem_read = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("lat1_resp_pattern", 32'(f_d_mem_resp), 32'(k % 2));
    end
    @(posedge clk); #1;
    f_d_mem_read = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    check("sb1_empty", 32'(sb1_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
